// File: rtl/barcode_reader.sv
// Serial barcode station-ID reader: measures the start-bit low time, then samples each
// data bit at that same delay after its falling edge to decode an 8-bit ID.
//
// state       | meaning
// IDLE        | waiting for a start-bit falling edge
// START_LOW   | timing the start-bit low phase
// WAIT_FALL   | waiting for the falling edge that begins the next data bit
// SAMPLE_WAIT | counting up to the captured start-bit time, then sampling
module barcode_reader #(
    parameter int TMR_W = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        START_LOW   = 2'd1,
        WAIT_FALL   = 2'd2,
        SAMPLE_WAIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_bc_ff1;
    logic             r_bc_s;
    logic             r_bc_q;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [TMR_W-1:0] r_cap;
    logic [TMR_W-1:0] w_cap_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [7:0]       r_id;
    logic             r_id_vld;
    logic             w_fall;
    logic             w_rise;
    logic             w_tmr_max;

    // Sync flops idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bc_ff1 <= 1'b1;
            r_bc_s   <= 1'b1;
            r_bc_q   <= 1'b1;
        end else begin
            r_bc_ff1 <= BC;
            r_bc_s   <= r_bc_ff1;
            r_bc_q   <= r_bc_s;
        end
    end

    assign w_fall    = r_bc_q & ~r_bc_s;
    assign w_rise    = ~r_bc_q & r_bc_s;
    assign w_tmr_max = &r_timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_cap     <= '0;
            r_shift   <= 8'h00;
            r_bit_cnt <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_cap     <= w_cap_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_cap_nxt     = r_cap;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = START_LOW;
                    w_timer_nxt   = '0;
                    w_bit_cnt_nxt = 4'd0;
                end
            end
            START_LOW: begin
                if (w_tmr_max) begin
                    w_state_nxt = IDLE;
                end else if (w_rise) begin
                    w_cap_nxt   = r_timer;
                    w_timer_nxt = '0;
                    // A zero-length start bit gives no usable sample delay.
                    w_state_nxt = (r_timer == '0) ? IDLE : WAIT_FALL;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (w_tmr_max) begin
                    w_state_nxt = IDLE;
                end else if (w_fall) begin
                    w_timer_nxt = '0;
                    w_state_nxt = SAMPLE_WAIT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            SAMPLE_WAIT: begin
                w_timer_nxt = r_timer + 1'b1;
                if (w_tmr_max) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == r_cap) begin
                    w_shift_nxt   = {r_shift[6:0], r_bc_s};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_FALL;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A completed frame takes priority over a coincident clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id     <= 8'h00;
            r_id_vld <= 1'b0;
        end else if (r_done && (r_shift[7:6] == 2'b00)) begin
            r_id     <= r_shift;
            r_id_vld <= 1'b1;
        end else if (clr_ID_vld) begin
            r_id_vld <= 1'b0;
        end
    end

    assign ID     = r_id;
    assign ID_vld = r_id_vld;

endmodule

// File: tb/tb_barcode_reader.sv
// Bench for barcode_reader: frame-level reference model (pulse widths -> bits -> ID update
// cycle) checked every cycle, plus literal checks and timeout cases on a narrow-timer instance.
module tb_barcode_reader;

    typedef struct {
        int         due;
        bit         is_clr;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BC = 1'b1;
    logic       BC8 = 1'b1;
    logic       clr_dir = 1'b0;
    logic       clr_rnd = 1'b0;
    logic       clr8 = 1'b0;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;
    logic [7:0] ID8;
    logic       ID_vld8;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         clr_rnd_en = 1'b0;
    ev_t        evq[$];
    logic [7:0] exp_id = 8'h00;
    logic       exp_vld = 1'b0;

    localparam int SP  = 'h20A;
    localparam int SL  = 'h105;
    localparam int SL1 = 'h82;
    localparam int SL0 = 'h186;

    assign clr_ID_vld = clr_dir | clr_rnd;

    barcode_reader u_dut (
        .clk        (clk),
        .rst        (rst),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld)
    );

    barcode_reader #(.TMR_W(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .BC         (BC8),
        .clr_ID_vld (clr8),
        .ID         (ID8),
        .ID_vld     (ID_vld8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input bit sel, input logic v);
        if (sel) BC8 = v;
        else     BC = v;
    endtask

    // The reader samples each bit L cycles after its falling edge (L = start-bit low time):
    // still low -> 0, already high -> 1. The ID becomes visible 8P+L+4 cycles after the
    // start-bit drive (2 sync stages, edge detect, sample, output register).
    task automatic send_frame(input bit sel, input logic [7:0] b, input int p, input int l,
                              input int l1, input int l0, input int nbits, input bit model);
        int         k0;
        int         lb;
        logic [7:0] dec;
        k0  = cyc;
        dec = 8'h00;
        for (int i = 0; i < 8; i++) begin
            lb  = b[7-i] ? l1 : l0;
            dec = {dec[6:0], (lb <= l)};
        end
        if (model && nbits == 8) evq.push_back('{k0 + 8*p + l + 4, 1'b0, dec});
        line(sel, 1'b0); wait_cyc(l);
        line(sel, 1'b1); wait_cyc(p - l);
        for (int i = 0; i < nbits; i++) begin
            lb = b[7-i] ? l1 : l0;
            line(sel, 1'b0); wait_cyc(lb);
            line(sel, 1'b1); wait_cyc(p - lb);
        end
    endtask

    task automatic pulse_clr();
        clr_dir = 1'b1;
        evq.push_back('{cyc + 1, 1'b1, 8'h00});
        wait_cyc(1);
        clr_dir = 1'b0;
    endtask

    always @(negedge clk) begin
        bit         do_clr;
        bit         do_set;
        logic [7:0] nv;
        int         i;
        if (rst) begin
            evq.delete();
            exp_id  = 8'h00;
            exp_vld = 1'b0;
        end else begin
            do_clr = 1'b0;
            do_set = 1'b0;
            nv     = exp_id;
            i      = 0;
            while (i < evq.size()) begin
                if (evq[i].due <= cyc) begin
                    if (evq[i].is_clr) do_clr = 1'b1;
                    else if (evq[i].val[7:6] == 2'b00) begin
                        do_set = 1'b1;
                        nv     = evq[i].val;
                    end
                    evq.delete(i);
                end else begin
                    i++;
                end
            end
            if (do_clr) exp_vld = 1'b0;
            if (do_set) begin
                exp_id  = nv;
                exp_vld = 1'b1;
            end
            check("model_id", ID, exp_id);
            check("model_id_vld", {7'd0, ID_vld}, {7'd0, exp_vld});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (clr_rnd_en && $urandom_range(0, 99) < 3) begin
                clr_rnd = 1'b1;
                evq.push_back('{cyc + 1, 1'b1, 8'h00});
            end else begin
                clr_rnd = 1'b0;
            end
        end
    end

    initial begin
        int         p;
        logic [7:0] b;
        wait_cyc(3);
        check("reset_id", ID, 8'h00);
        check("reset_vld", {7'd0, ID_vld}, 8'h00);
        rst = 1'b0;
        wait_cyc(3);
        check("idle_vld", {7'd0, ID_vld}, 8'h00);

        send_frame(0, 8'h25, SP, SL, SL1, SL0, 8, 1);
        check("frame25_id", ID, 8'h25);
        check("frame25_vld", {7'd0, ID_vld}, 8'h01);

        send_frame(0, 8'hC5, SP, SL, SL1, SL0, 8, 1);
        check("badC5_id", ID, 8'h25);
        check("badC5_vld", {7'd0, ID_vld}, 8'h01);

        pulse_clr();
        wait_cyc(1);
        check("clr_vld", {7'd0, ID_vld}, 8'h00);
        check("clr_id", ID, 8'h25);

        // Clear request lands on the same edge as frame 0x13 completes.
        fork
            send_frame(0, 8'h13, SP, SL, SL1, SL0, 8, 1);
            begin
                wait_cyc(8*SP + SL + 3);
                pulse_clr();
            end
        join
        check("coinc_id", ID, 8'h13);
        check("coinc_vld", {7'd0, ID_vld}, 8'h01);

        send_frame(0, 8'h3A, SP, SL, SL1, SL0, 4, 0);
        rst = 1'b1;
        wait_cyc(1);
        check("midrst_id", ID, 8'h00);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        check("postrst_vld", {7'd0, ID_vld}, 8'h00);
        send_frame(0, 8'h11, SP, SL, SL1, SL0, 8, 1);
        check("frame11_id", ID, 8'h11);
        check("frame11_vld", {7'd0, ID_vld}, 8'h01);

        send_frame(0, 8'h01, SP, SL, SL1, SL0, 8, 1);
        check("b2b01_id", ID, 8'h01);
        wait_cyc(SP);
        send_frame(0, 8'h2F, SP, SL, SL1, SL0, 8, 1);
        check("b2b2F_id", ID, 8'h2F);
        check("b2b2F_vld", {7'd0, ID_vld}, 8'h01);

        clr_rnd_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            p = $urandom_range(24, 160);
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) b = b & 8'h3F;
            send_frame(0, b, p, p / 2, p / 4, (3 * p) / 4, 8, 1);
            wait_cyc($urandom_range(0, p));
        end
        clr_rnd_en = 1'b0;
        wait_cyc(5);

        // Narrow-timer instance: timeouts in WAIT_FALL and START_LOW, and zero capture.
        check("t8_reset_vld", {7'd0, ID_vld8}, 8'h00);
        line(1, 1'b0); wait_cyc(32);
        line(1, 1'b1); wait_cyc(300);
        check("t8_wf_timeout_vld", {7'd0, ID_vld8}, 8'h00);
        send_frame(1, 8'h15, 64, 32, 16, 48, 8, 0);
        check("t8_after_wf_id", ID8, 8'h15);
        check("t8_after_wf_vld", {7'd0, ID_vld8}, 8'h01);

        line(1, 1'b0); wait_cyc(300);
        line(1, 1'b1); wait_cyc(100);
        send_frame(1, 8'h0B, 64, 32, 16, 48, 8, 0);
        check("t8_after_sl_id", ID8, 8'h0B);

        line(1, 1'b0); wait_cyc(1);
        line(1, 1'b1); wait_cyc(100);
        send_frame(1, 8'h27, 64, 32, 16, 48, 8, 0);
        check("t8_cap0_id", ID8, 8'h27);
        check("t8_cap0_vld", {7'd0, ID_vld8}, 8'h01);

        wait_cyc(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/barcode_reader.md
BARCODE_READER -- requirements
Module: barcode_reader

Interface
REQ-001 SHALL have parameter TMR_W, default 22, meaning width of the bit-timing counter (max measurable start-bit low time 2^TMR_W-1 clocks).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port BC  input  1  raw barcode serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port clr_ID_vld  input  1  single-cycle request to clear ID_vld.
REQ-006 SHALL have port ID  output  8  last valid station ID received.
REQ-007 SHALL have port ID_vld  output  1  high while a valid, unconsumed ID is held.

Function
REQ-008 SHALL pass BC through two flops (bc_s), then a third (bc_q); fall = bc_q & ~bc_s; rise = ~bc_q & bc_s.
REQ-009 SHALL decode frames of 1 start bit then 8 data bits, MSB first; each bit begins with a BC falling edge.
REQ-010 SHALL use FSM states IDLE, START_LOW, WAIT_FALL, SAMPLE_WAIT.
REQ-011 IDLE: on fall -> START_LOW, timer cleared to 0, bit count cleared to 0.
REQ-012 START_LOW: timer increments each cycle; on rise -> capture register loaded with timer value, timer cleared, -> WAIT_FALL.
REQ-013 WAIT_FALL: timer increments each cycle; on fall -> timer cleared, -> SAMPLE_WAIT.
REQ-014 SAMPLE_WAIT: timer increments each cycle; in the cycle timer equals capture, bc_s shifts into the shift register LSB (left shift) and bit count increments.
REQ-015 After a sample with bit count <8 after increment -> WAIT_FALL; at 8 -> IDLE and frame complete.
REQ-016 On frame complete, if shift[7:6]==2'b00, ID SHALL load shift and ID_vld SHALL go high the next cycle; otherwise ID and ID_vld unchanged.
REQ-017 Timeout: if timer reaches all-ones in START_LOW, WAIT_FALL or SAMPLE_WAIT -> IDLE; frame discarded, ID/ID_vld unchanged.
REQ-018 A capture of 0 (start-bit low shorter than one cycle after sync) SHALL be treated as timeout -> IDLE.
REQ-019 clr_ID_vld SHALL clear ID_vld next cycle; ID retains its value.
REQ-020 Simultaneous valid-frame set and clr_ID_vld: set wins, ID_vld=1 with new ID.
REQ-021 A new valid frame while ID_vld=1 SHALL overwrite ID; ID_vld stays 1.
REQ-022 Falls in SAMPLE_WAIT before the sample point SHALL be ignored.
REQ-023 bc_s low in IDLE without a fall (e.g. line low out of reset) SHALL NOT start a frame.

Reset
REQ-024 rst high SHALL immediately force state IDLE, timer, capture, shift, bit count, ID=8'h00, ID_vld=0.
REQ-025 Sync flops SHALL reset to 1 (idle line) so no spurious fall follows reset release.
REQ-026 rst asserted mid-frame SHALL abort the frame; after release, decoding resumes only on the next fall from IDLE.

Verification
REQ-027 Period 0x20A, start low 0x105, '1' low 0x82, '0' low 0x186, send 0x25 -> ID=0x25, ID_vld=1 one cycle after 8th sample.
REQ-028 Same timing, send 0xC5 after a prior 0x25 -> ID stays 0x25, ID_vld unchanged, FSM back in IDLE.
REQ-029 ID_vld=1, pulse clr_ID_vld one cycle -> ID_vld=0 next cycle, ID still 0x25; clr coincident with completion of frame 0x13 -> ID=0x13, ID_vld=1.
REQ-030 Start bit then BC held high, TMR_W=8 -> return to IDLE after 255 cycles in WAIT_FALL, ID_vld=0.
REQ-031 Assert rst after 4 data bits of 0x3A, release, send full 0x11 -> ID=0x11, ID_vld=1, no residue from aborted frame.
REQ-032 Back-to-back frames 0x01 then 0x2F with one bit period idle between -> ID=0x01 then 0x2F, ID_vld remains 1 throughout second frame.
